// File: rtl/ahb_spi_pkg.sv
// Shared register map, bit positions and engine state encoding for the AHB SPI FIFO master.
package ahb_spi_pkg;

  // Word offsets as seen on HADDR[4:2]
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_SS     = 3'd2;
  localparam logic [2:0] REG_TXDATA = 3'd3;
  localparam logic [2:0] REG_RXDATA = 3'd4;

  localparam int CTRL_CPOL    = 0;
  localparam int CTRL_CPHA    = 1;
  localparam int CTRL_EN      = 2;
  localparam int CTRL_DIV_LSB = 8;

  localparam int ST_TX_EMPTY = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_BUSY     = 4;
  localparam int ST_TX_OVF   = 5;
  localparam int ST_RX_OVF   = 6;

  typedef enum logic [1:0] {
    ENG_IDLE  = 2'd0,
    ENG_SHIFT = 2'd1,
    ENG_DONE  = 2'd2
  } eng_state_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock byte FIFO with a combinational head; a same-cycle pop makes room for a push when full.
module spi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge HCLK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push != do_pop) count <= do_push ? count + (AW+1)'(1) : count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/ahb_spi_fifo_master.sv
// Zero-wait-state AHB-Lite slave with TX/RX byte FIFOs feeding a mode-programmable SPI master engine.
//   state | meaning
//   IDLE  | wait for EN and a queued TX byte; SCLK parked at CPOL
//   SHIFT | 16 half-periods of CLKDIV+1 cycles, MSB first
//   DONE  | one cycle; received byte pushed into RX
module ahb_spi_fifo_master
  import ahb_spi_pkg::*;
#(
  parameter int NUM_SS     = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic              HREADY,
  input  logic [1:0]        HTRANS,
  input  logic [31:0]       HADDR,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  input  logic              SPI_MISO_i,
  output logic              SPI_MOSI_o,
  output logic [NUM_SS-1:0] SPI_SS_o,
  output logic              SPI_CLK_o
);
  logic [2:0]        dp_addr;
  logic              dp_write, dp_valid, wr_en, rd_en;
  logic              ctrl_cpol, ctrl_cpha, ctrl_en;
  logic [7:0]        ctrl_div;
  logic [NUM_SS-1:0] ss_reg;
  logic              tx_ovf, rx_ovf, busy;
  logic [31:0]       status;
  eng_state_t        state;
  logic [7:0]        shreg, div_cnt, div_l;
  logic [3:0]        half_cnt;
  logic              cpha_l, rx_bit, sclk, mosi;
  logic              tx_push, tx_pop, tx_full, tx_empty;
  logic              rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]        tx_head, rx_head;
  logic              unused_bus;

  assign unused_bus = ^{HSIZE, HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA};

  assign HREADYOUT  = 1'b1;
  assign SPI_SS_o   = ss_reg;
  assign SPI_CLK_o  = sclk;
  assign SPI_MOSI_o = mosi;

  assign wr_en   = dp_valid & dp_write;
  assign rd_en   = dp_valid & ~dp_write;
  assign tx_push = wr_en & (dp_addr == REG_TXDATA);
  assign rx_pop  = rd_en & (dp_addr == REG_RXDATA);
  assign tx_pop  = (state == ENG_IDLE) & ctrl_en & ~tx_empty;
  assign rx_push = (state == ENG_DONE);
  // A start pending in IDLE counts as busy so a queued byte reports busy from the cycle it is picked up
  assign busy    = (state != ENG_IDLE) | tx_pop;

  spi_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .HCLK(HCLK), .HRESETn(HRESETn), .push(tx_push), .pop(tx_pop), .wdata(HWDATA[7:0]),
    .rdata(tx_head), .full(tx_full), .empty(tx_empty)
  );

  spi_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .HCLK(HCLK), .HRESETn(HRESETn), .push(rx_push), .pop(rx_pop), .wdata(shreg),
    .rdata(rx_head), .full(rx_full), .empty(rx_empty)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_addr  <= '0;
      dp_write <= 1'b0;
    end else begin
      dp_valid <= HSEL & HREADY & HTRANS[1];
      if (HSEL && HREADY && HTRANS[1]) begin
        dp_addr  <= HADDR[4:2];
        dp_write <= HWRITE;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl_cpol <= 1'b0;
      ctrl_cpha <= 1'b0;
      ctrl_en   <= 1'b0;
      ctrl_div  <= '0;
      ss_reg    <= '1;
      tx_ovf    <= 1'b0;
      rx_ovf    <= 1'b0;
    end else begin
      if (wr_en && dp_addr == REG_CTRL) begin
        ctrl_cpol <= HWDATA[CTRL_CPOL];
        ctrl_cpha <= HWDATA[CTRL_CPHA];
        ctrl_en   <= HWDATA[CTRL_EN];
        ctrl_div  <= HWDATA[CTRL_DIV_LSB +: 8];
      end
      if (wr_en && dp_addr == REG_SS) ss_reg <= HWDATA[NUM_SS-1:0];
      if (tx_push && tx_full && !tx_pop) tx_ovf <= 1'b1;
      else if (wr_en && dp_addr == REG_STATUS && HWDATA[ST_TX_OVF]) tx_ovf <= 1'b0;
      if (rx_push && rx_full && !rx_pop) rx_ovf <= 1'b1;
      else if (wr_en && dp_addr == REG_STATUS && HWDATA[ST_RX_OVF]) rx_ovf <= 1'b0;
    end
  end

  always_comb begin
    status              = '0;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_TX_FULL]  = tx_full;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_BUSY]     = busy;
    status[ST_TX_OVF]   = tx_ovf;
    status[ST_RX_OVF]   = rx_ovf;
  end

  always_comb begin
    HRDATA = '0;
    if (rd_en) begin
      case (dp_addr)
        REG_CTRL: begin
          HRDATA[CTRL_CPOL]           = ctrl_cpol;
          HRDATA[CTRL_CPHA]           = ctrl_cpha;
          HRDATA[CTRL_EN]             = ctrl_en;
          HRDATA[CTRL_DIV_LSB +: 8]   = ctrl_div;
        end
        REG_STATUS: HRDATA = status;
        REG_SS:     HRDATA[NUM_SS-1:0] = ss_reg;
        REG_RXDATA: if (!rx_empty) HRDATA[7:0] = rx_head;
        default: ;
      endcase
    end
  end

  // Mode and divider are latched at start so CTRL writes mid-byte only affect the next byte
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= ENG_IDLE;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      shreg    <= '0;
      rx_bit   <= 1'b0;
      div_cnt  <= '0;
      div_l    <= '0;
      half_cnt <= '0;
      cpha_l   <= 1'b0;
    end else begin
      case (state)
        ENG_IDLE: begin
          sclk <= ctrl_cpol;
          if (tx_pop) begin
            state    <= ENG_SHIFT;
            shreg    <= tx_head;
            cpha_l   <= ctrl_cpha;
            div_l    <= ctrl_div;
            div_cnt  <= ctrl_div;
            half_cnt <= 4'd15;
            if (!ctrl_cpha) mosi <= tx_head[7];
          end
        end
        ENG_SHIFT: begin
          if (div_cnt != 8'd0) begin
            div_cnt <= div_cnt - 8'd1;
          end else begin
            div_cnt <= div_l;
            sclk    <= ~sclk;
            // Odd half_cnt marks the end of a leading half-period
            if (half_cnt[0]) begin
              if (cpha_l) mosi   <= shreg[7];
              else        rx_bit <= SPI_MISO_i;
            end else if (cpha_l) begin
              shreg <= {shreg[6:0], SPI_MISO_i};
            end else begin
              shreg <= {shreg[6:0], rx_bit};
              mosi  <= shreg[6];
            end
            if (half_cnt == 4'd0) state <= ENG_DONE;
            else                  half_cnt <= half_cnt - 4'd1;
          end
        end
        ENG_DONE: state <= ENG_IDLE;
        default:  state <= ENG_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_spi_fifo_master.sv
// Randomised bench for ahb_spi_fifo_master with MOSI looped to MISO and a queue-level reference model.
module tb_ahb_spi_fifo_master;
  localparam int NUM_SS = 4;
  localparam int DEPTH  = 8;
  localparam logic [31:0] A_CTRL = 32'h00, A_STATUS = 32'h04, A_SS = 32'h08,
                          A_TX = 32'h0C, A_RX = 32'h10;

  logic HCLK = 1'b0, HRESETn = 1'b0, HSEL = 1'b0, HREADY = 1'b1, HWRITE = 1'b0;
  logic [1:0]  HTRANS = 2'b00;
  logic [31:0] HADDR = '0, HWDATA = '0;
  logic [2:0]  HSIZE = 3'd2;
  logic [31:0] HRDATA;
  logic        HREADYOUT, SPI_MISO_i, SPI_MOSI_o, SPI_CLK_o;
  logic [NUM_SS-1:0] SPI_SS_o;

  assign SPI_MISO_i = SPI_MOSI_o;
  always #5 HCLK = ~HCLK;

  ahb_spi_fifo_master #(.NUM_SS(NUM_SS), .FIFO_DEPTH(DEPTH)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY), .HTRANS(HTRANS),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .SPI_MISO_i(SPI_MISO_i), .SPI_MOSI_o(SPI_MOSI_o),
    .SPI_SS_o(SPI_SS_o), .SPI_CLK_o(SPI_CLK_o)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  bit tx_ovf_m = 1'b0, rx_ovf_m = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge HCLK); HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = 1'b1;
    @(negedge HCLK); HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge HCLK); HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = 1'b0;
    @(negedge HCLK); HSEL = 1'b0; HTRANS = 2'b00;
    #1 d = HRDATA;
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s = '0;
    s[0] = (tx_q.size() == 0);
    s[1] = (tx_q.size() == DEPTH);
    s[2] = (rx_q.size() == 0);
    s[3] = (rx_q.size() == DEPTH);
    s[5] = tx_ovf_m;
    s[6] = rx_ovf_m;
    return s;
  endfunction

  task automatic tx_write(input logic [7:0] b);
    bus_write(A_TX, {$urandom_range(0, 255) << 8} | 32'(b));
    if (tx_q.size() < DEPTH) tx_q.push_back(b);
    else tx_ovf_m = 1'b1;
  endtask

  // Every queued byte loops back into RX once the engine has gone idle
  task automatic model_drain();
    while (tx_q.size() > 0) begin
      logic [7:0] b = tx_q.pop_front();
      if (rx_q.size() < DEPTH) rx_q.push_back(b);
      else rx_ovf_m = 1'b1;
    end
  endtask

  task automatic rx_check(input string tag);
    logic [31:0] d;
    logic [31:0] e;
    e = (rx_q.size() == 0) ? 32'd0 : 32'(rx_q.pop_front());
    bus_read(A_RX, d);
    check_eq(tag, d, e);
  endtask

  task automatic status_check(input string tag);
    logic [31:0] d;
    bus_read(A_STATUS, d);
    check_eq(tag, d, exp_status());
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] s;
    int n = 0;
    do begin
      bus_read(A_STATUS, s);
      n++;
    end while (s[4] && n < 300);
    check_eq({tag, "_idle"}, {31'd0, s[4]}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  b;
    logic        cpol, cpha;
    int          busy_n, rises, last_rise, bad_int;
    bit          seen;
    logic [7:0]  cap;
    logic        prev_clk;

    repeat (3) @(negedge HCLK);
    check_eq("rst_sclk", {31'd0, SPI_CLK_o}, 32'd0);
    check_eq("rst_ss", 32'(SPI_SS_o), 32'hF);
    HRESETn = 1'b1;
    check_eq("rst_mosi", {31'd0, SPI_MOSI_o}, 32'd0);
    check_eq("rst_hrdata", HRDATA, 32'd0);
    check_eq("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    bus_read(A_STATUS, d); check_eq("rst_status", d, 32'h05);
    bus_read(A_CTRL, d);   check_eq("rst_ctrl", d, 32'h0);

    // SS register drives the pins the cycle after the data phase
    bus_write(A_SS, 32'h0000_000E);
    check_eq("ss_before", 32'(SPI_SS_o), 32'hF);
    @(negedge HCLK);
    check_eq("ss_after", 32'(SPI_SS_o), 32'hE);
    bus_write(A_SS, 32'hFFFF_FFF3);
    bus_read(A_SS, d);     check_eq("ss_mask", d, 32'h3);
    bus_read(32'h14, d);   check_eq("unmapped_rd", d, 32'h0);
    bus_write(32'h18, 32'hFFFF_FFFF);
    bus_read(A_TX, d);     check_eq("txdata_rd", d, 32'h0);
    bus_read(A_CTRL, d);   check_eq("ctrl_unaffected", d, 32'h0);
    bus_write(A_CTRL, 32'hFFFF_00F8 | (32'h5A << 8));
    bus_read(A_CTRL, d);   check_eq("ctrl_rw", d, 32'h0000_5A00);
    bus_write(A_SS, 32'hF);

    // Loopback in every mode at CLKDIV=0
    for (int m = 0; m < 4; m++) begin
      cpol = m[0];
      cpha = m[1];
      bus_write(A_CTRL, {29'd1, cpha, cpol});
      bus_write(A_TX, 32'h0000_00A5);
      tx_q.push_back(8'hA5);
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = A_STATUS; HWRITE = 1'b0;
      busy_n = 0; seen = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(negedge HCLK); #1;
        if (HRDATA[4]) begin busy_n++; seen = 1'b1; end
        else if (seen) break;
      end
      HSEL = 1'b0; HTRANS = 2'b00;
      check_eq($sformatf("busy_len_m%0d", m), busy_n, 18);
      wait_idle($sformatf("a5_m%0d", m));
      model_drain();
      rx_check($sformatf("rx_a5_m%0d", m));
      for (int k = 0; k < 2; k++) begin
        b = 8'($urandom);
        tx_write(b);
        wait_idle($sformatf("rnd_m%0d", m));
        model_drain();
        rx_check($sformatf("rx_rnd_m%0d_%0d", m, k));
      end
      check_eq($sformatf("sclk_idle_m%0d", m), {31'd0, SPI_CLK_o}, {31'd0, cpol});
    end

    // CLKDIV=3 timing and MSB-first order on MOSI
    bus_write(A_CTRL, 32'h0000_0304);
    bus_write(A_TX, 32'h0000_003C);
    tx_q.push_back(8'h3C);
    rises = 0; last_rise = 0; bad_int = 0; cap = '0; prev_clk = SPI_CLK_o;
    for (int c = 0; c < 120; c++) begin
      @(negedge HCLK);
      if (!prev_clk && SPI_CLK_o) begin
        if (rises > 0 && (c - last_rise) != 8) bad_int++;
        last_rise = c;
        rises++;
        cap = {cap[6:0], SPI_MOSI_o};
      end
      prev_clk = SPI_CLK_o;
    end
    check_eq("sclk_pulses", rises, 8);
    check_eq("sclk_period_bad", bad_int, 0);
    check_eq("mosi_msb_first", 32'(cap), 32'h3C);
    wait_idle("div3");
    model_drain();
    rx_check("rx_div3");

    // TX overflow while disabled, W1C behaviour, then RX overflow on drain
    bus_write(A_CTRL, 32'h0);
    for (int k = 0; k < DEPTH + 1; k++) tx_write(8'($urandom));
    status_check("tx_full_ovf");
    bus_write(A_STATUS, 32'h40);
    rx_ovf_m = 1'b0;
    status_check("w1c_rx_only");
    bus_write(A_STATUS, 32'h20);
    tx_ovf_m = 1'b0;
    status_check("w1c_tx");
    bus_write(A_CTRL, {29'd1, 2'($urandom)});
    wait_idle("drain8");
    model_drain();
    status_check("rx_full");
    tx_write(8'($urandom));
    wait_idle("drain9");
    model_drain();
    status_check("rx_ovf");
    for (int k = 0; k < DEPTH; k++) rx_check($sformatf("rx_order_%0d", k));
    bus_write(A_STATUS, 32'h40);
    rx_ovf_m = 1'b0;
    status_check("rx_empty_pre");
    rx_check("rx_empty_read");
    status_check("rx_empty_post");

    // Clearing EN and changing CLKDIV mid-byte: current byte finishes on old divider, no new start
    bus_write(A_CTRL, 32'h0000_0104);
    b = 8'($urandom);
    tx_write(b);
    tx_write(8'($urandom));
    bus_write(A_CTRL, 32'h0000_7F00);
    repeat (40) @(negedge HCLK);
    rx_q.push_back(tx_q.pop_front());
    status_check("en_clear_mid");
    rx_check("en_clear_rx");

    // Asynchronous reset in the middle of a byte
    bus_write(A_SS, 32'h5);
    bus_write(A_CTRL, 32'h0000_0305);
    tx_write(8'($urandom));
    repeat (20) @(negedge HCLK);
    #2 HRESETn = 1'b0;
    #1;
    check_eq("arst_sclk", {31'd0, SPI_CLK_o}, 32'd0);
    check_eq("arst_ss", 32'(SPI_SS_o), 32'hF);
    tx_q.delete(); rx_q.delete(); tx_ovf_m = 1'b0; rx_ovf_m = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    bus_read(A_STATUS, d); check_eq("arst_status", d, 32'h05);
    status_check("arst_model");
    bus_read(A_CTRL, d);   check_eq("arst_ctrl", d, 32'h0);
    repeat (80) @(negedge HCLK);
    status_check("arst_no_push");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_spi_fifo_master.md
AHB_SPI_FIFO_MASTER -- requirements
Module: ahb_spi_fifo_master

Interface
REQ-001 SHALL have parameter NUM_SS, default 4, meaning the number of active-low slave-select lines (1..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning the byte depth of each of the TX and RX FIFOs (power of two, 2..256).
REQ-003 SHALL have one clock, HCLK; reset is HRESETn, asynchronous and active-low.
REQ-004 SHALL have these ports:
- HCLK  in  1  clock
- HRESETn  in  1  async active-low reset
- HSEL  in  1  slave select
- HREADY  in  1  bus ready (previous transfer completing)
- HTRANS  in  2  transfer type
- HADDR  in  32  address
- HWRITE  in  1  write
- HSIZE  in  3  size (ignored)
- HWDATA  in  32  write data
- HRDATA  out  32  read data
- HREADYOUT  out  1  ready
- SPI_MISO_i  in  1  serial in
- SPI_MOSI_o  out  1  serial out
- SPI_SS_o  out  NUM_SS  slave selects, active-low
- SPI_CLK_o  out  1  SCLK

Function
REQ-005 SHALL drive HREADYOUT=1 always (zero wait states).
REQ-006 SHALL register HADDR[4:2] and HWRITE in the address phase only when HSEL & HREADY & HTRANS[1], and act on HWDATA/HRDATA in the following data phase.
REQ-007 SHALL decode the following registers:
- 0x00 CTRL (RW): bit0 CPOL, bit1 CPHA, bit2 EN, [15:8] CLKDIV
- 0x04 STATUS: bit0 TX_EMPTY, bit1 TX_FULL, bit2 RX_EMPTY, bit3 RX_FULL, bit4 BUSY, bit5 TX_OVF, bit6 RX_OVF
- 0x08 SS (RW, NUM_SS bits)
- 0x0C TXDATA (WO, [7:0])
- 0x10 RXDATA (RO, [7:0])
REQ-008 SHALL read unused bits and unmapped offsets as 0; writes to them SHALL have no effect.
REQ-009 SHALL clear TX_OVF/RX_OVF on a STATUS write with 1 in the corresponding bit (W1C); other STATUS bits are read-only.
REQ-010 SHALL drive SPI_SS_o directly from the SS register; the engine SHALL never alter it.
REQ-011 A TXDATA write SHALL push HWDATA[7:0] at the end of the data-phase cycle; if TX is full, the byte SHALL be dropped and TX_OVF set.
REQ-012 An RXDATA read SHALL return the FIFO head combinationally and pop at the end of the data phase; if RX is empty, it SHALL return 0 with no pop.
REQ-013 Simultaneous push and pop on a FIFO SHALL both succeed, including when that FIFO is full (pop first) or empty (push only).
REQ-014 The engine SHALL implement states IDLE, SHIFT and DONE:
- IDLE->SHIFT when EN=1 and TX is non-empty; pop one TX byte into the shift register
- SHIFT runs 16 half-periods of (CLKDIV+1) HCLK cycles each
- SHIFT->DONE after the 16th half-period
- DONE->IDLE after one cycle; push the RX byte in DONE
REQ-015 SCLK SHALL idle at CPOL and toggle at each half-period boundary; transfers are MSB first.
REQ-016 SHALL shift data as follows:
- CPHA=0: present MOSI bit 7 on entering SHIFT, sample MISO on leading edges, shift on trailing edges
- CPHA=1: shift on leading edges, sample on trailing edges
REQ-017 BUSY SHALL be 1 whenever the state is not IDLE.
REQ-018 At DONE with RX full, the received byte SHALL be dropped and RX_OVF set.
REQ-019 Clearing EN mid-byte SHALL let the current byte complete and prevent further starts; CTRL writes during SHIFT SHALL take effect only at the next IDLE->SHIFT.
REQ-020 Minimum byte-to-byte spacing SHALL be 16*(CLKDIV+1)+2 HCLK cycles.

Reset
REQ-021 On HRESETn low, the block SHALL reset as follows:
- CTRL=0
- SS all ones
- both FIFOs empty and OVF flags 0
- state IDLE
- SPI_CLK_o=0, SPI_MOSI_o=0, HRDATA=0
- address-phase registers cleared
REQ-022 Reset asserted mid-transfer SHALL abort immediately with no RX push.

Structure
REQ-023 Package ahb_spi_pkg SHALL hold the register offsets, STATUS/CTRL bit indices and the engine state encoding.
REQ-024 The block SHALL instance sub-module spi_sync_fifo (parametrised width 8 and depth FIFO_DEPTH, with full/empty outputs) twice, for TX and RX.

Verification
REQ-025 Loopback (MOSI tied to MISO) with CLKDIV=0 in all four CPOL/CPHA modes: write 0xA5 -> RXDATA reads 0xA5, and BUSY lasts 18 cycles.
REQ-026 Fill TX with FIFO_DEPTH+1 writes while EN=0 -> TX_FULL=1 and TX_OVF=1; writing 0x40 to STATUS clears RX_OVF only and TX_OVF stays 1.
REQ-027 With EN=1, send FIFO_DEPTH+1 bytes without reading RX -> the last byte is dropped, RX_OVF=1, RX holds the first FIFO_DEPTH bytes in order.
REQ-028 With CLKDIV=3, write 0x3C and measure SCLK -> period is 8 HCLK cycles and 8 pulses; write SS=0xE -> SPI_SS_o=0xE the cycle after the data phase.
REQ-029 Assert HRESETn mid-byte -> SPI_CLK_o=0 and SS all ones asynchronously, RX_EMPTY=1, STATUS reads 0x05 after release.
REQ-030 Read RXDATA when RX is empty -> returns 0x00 and the FIFO state is unchanged.
